// File: rtl/d_reg_pipe.sv
// d_reg_pipe: WIDTH x DEPTH register pipeline (data -> q) with per-stage valid, flush, clear/hold on en=0, occupancy occ and tap_sel -> tap_q stage tap
module d_reg_pipe #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  parameter bit CLR_ON_DIS = 1,
  localparam int TW = DEPTH > 1 ? $clog2(DEPTH) : 1,
  localparam int OW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             flush,
  input  logic [WIDTH-1:0] data,
  input  logic             data_vld,
  output logic [WIDTH-1:0] q,
  output logic             q_vld,
  input  logic [TW-1:0]    tap_sel,
  output logic [WIDTH-1:0] tap_q,
  output logic [OW-1:0]    occ
);
  logic [WIDTH-1:0] s [DEPTH];
  logic [DEPTH-1:0] v;
  logic [OW-1:0]    cnt;
  logic             clr;
  assign clr = flush || (!en && CLR_ON_DIS);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) s[i] <= '0;
      v <= '0;
      cnt <= '0;
    end else if (clr) begin
      for (int i = 0; i < DEPTH; i++) s[i] <= '0;
      v <= '0;
      cnt <= '0;
    end else if (en) begin
      s[0] <= data_vld ? data : '0;
      v[0] <= data_vld;
      for (int i = 1; i < DEPTH; i++) begin
        s[i] <= s[i-1];
        v[i] <= v[i-1];
      end
      cnt <= cnt + OW'(data_vld) - OW'(v[DEPTH-1]);
    end
  always_comb begin
    tap_q = '0;
    for (int i = 0; i < DEPTH; i++) tap_q = tap_sel == TW'(i) ? s[i] : tap_q;
  end
  assign q = s[DEPTH-1];
  assign q_vld = v[DEPTH-1];
  assign occ = cnt;
endmodule

// File: tb/tb_d_reg_pipe.sv
// tb_d_reg_pipe: four d_reg_pipe configurations on shared stimulus, checked against a queue model plus literal scenario checks
module tb_d_reg_pipe;
  logic clk = 0;
  logic rst_n = 0;
  logic en = 0;
  logic flush = 0;
  logic [7:0] data = 0;
  logic data_vld = 0;
  logic [7:0] q_a [4];
  logic [7:0] tap_a [4];
  logic qv_a [4];
  logic [3:0] occ_a [4];
  logic [2:0] oc0, oc1, oc2;
  logic [0:0] oc3;
  logic [1:0] ts0, ts1;
  logic [2:0] ts2;
  logic [0:0] ts3;
  int tsv [4] = '{0, 0, 0, 0};
  int dep [4] = '{4, 4, 5, 1};
  int clrm [4] = '{1, 0, 0, 1};
  int tw [4] = '{2, 2, 3, 1};
  logic [8:0] mq [4][$];
  int checks = 0;
  int errors = 0;
  always #5 clk = ~clk;
  assign ts0 = 2'(tsv[0]);
  assign ts1 = 2'(tsv[1]);
  assign ts2 = 3'(tsv[2]);
  assign ts3 = 1'(tsv[3]);
  assign occ_a[0] = 4'(oc0);
  assign occ_a[1] = 4'(oc1);
  assign occ_a[2] = 4'(oc2);
  assign occ_a[3] = 4'(oc3);
  d_reg_pipe #(.WIDTH(8), .DEPTH(4), .CLR_ON_DIS(1)) u0 (.clk(clk), .rst_n(rst_n), .en(en), .flush(flush), .data(data), .data_vld(data_vld),
    .q(q_a[0]), .q_vld(qv_a[0]), .tap_sel(ts0), .tap_q(tap_a[0]), .occ(oc0));
  d_reg_pipe #(.WIDTH(8), .DEPTH(4), .CLR_ON_DIS(0)) u1 (.clk(clk), .rst_n(rst_n), .en(en), .flush(flush), .data(data), .data_vld(data_vld),
    .q(q_a[1]), .q_vld(qv_a[1]), .tap_sel(ts1), .tap_q(tap_a[1]), .occ(oc1));
  d_reg_pipe #(.WIDTH(8), .DEPTH(5), .CLR_ON_DIS(0)) u2 (.clk(clk), .rst_n(rst_n), .en(en), .flush(flush), .data(data), .data_vld(data_vld),
    .q(q_a[2]), .q_vld(qv_a[2]), .tap_sel(ts2), .tap_q(tap_a[2]), .occ(oc2));
  d_reg_pipe #(.WIDTH(8), .DEPTH(1), .CLR_ON_DIS(1)) u3 (.clk(clk), .rst_n(rst_n), .en(en), .flush(flush), .data(data), .data_vld(data_vld),
    .q(q_a[3]), .q_vld(qv_a[3]), .tap_sel(ts3), .tap_q(tap_a[3]), .occ(oc3));
  task automatic chk(string n, int a, int e);
    checks++;
    if (a != e) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h", n, a, e);
    end
  endtask
  task automatic model_clear();
    for (int k = 0; k < 4; k++) begin
      mq[k] = {};
      for (int i = 0; i < dep[k]; i++) mq[k].push_back(9'h0);
    end
  endtask
  task automatic model_edge();
    for (int k = 0; k < 4; k++) begin
      if (!rst_n || flush || (!en && clrm[k] != 0)) begin
        mq[k] = {};
        for (int i = 0; i < dep[k]; i++) mq[k].push_back(9'h0);
      end else if (en) begin
        mq[k].push_front(data_vld ? {1'b1, data} : 9'h0);
        void'(mq[k].pop_back());
      end
    end
  endtask
  task automatic compare_all();
    logic [8:0] e;
    int n;
    for (int k = 0; k < 4; k++) begin
      e = mq[k][dep[k]-1];
      chk($sformatf("q[%0d]", k), int'(q_a[k]), int'(e[7:0]));
      chk($sformatf("q_vld[%0d]", k), int'(qv_a[k]), int'(e[8]));
      n = 0;
      foreach (mq[k][i]) n += int'(mq[k][i][8]);
      chk($sformatf("occ[%0d]", k), int'(occ_a[k]), n);
      e = tsv[k] < dep[k] ? mq[k][tsv[k]] : 9'h0;
      chk($sformatf("tap_q[%0d] sel=%0d", k, tsv[k]), int'(tap_a[k]), int'(e[7:0]));
    end
  endtask
  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    compare_all();
  endtask
  task automatic drive(logic e_i, logic f_i, logic v_i, logic [7:0] d_i);
    en = e_i;
    flush = f_i;
    data_vld = v_i;
    data = d_i;
  endtask
  int oe [5] = '{1, 2, 3, 4, 4};
  int lat;
  initial begin
    model_clear();
    step();
    step();
    rst_n = 1;
    chk("reset q", int'(q_a[0]), 0);
    chk("reset occ", int'(occ_a[0]), 0);
    for (int i = 0; i < 5; i++) begin
      drive(1, 0, 1, 8'(8'h11 * (i + 1)));
      step();
      chk($sformatf("stream occ %0d", i), int'(occ_a[0]), oe[i]);
      if (i == 3) chk("stream q 11", int'(q_a[0]), 8'h11);
      if (i == 4) chk("stream q 22", int'(q_a[0]), 8'h22);
    end
    drive(1, 1, 1, 8'h5A);
    step();
    chk("flush occ", int'(occ_a[0]), 0);
    drive(1, 0, 1, 8'h10); step();
    drive(1, 0, 0, 8'hFF); step();
    drive(1, 0, 1, 8'h30); step();
    chk("bubble occ peak", int'(occ_a[0]), 2);
    drive(1, 0, 0, 8'hFF); step();
    chk("bubble q 10", int'(q_a[0]), 8'h10);
    chk("bubble vld 1", int'(qv_a[0]), 1);
    step();
    chk("bubble q 00", int'(q_a[0]), 0);
    chk("bubble vld 0", int'(qv_a[0]), 0);
    step();
    chk("bubble q 30", int'(q_a[0]), 8'h30);
    drive(1, 1, 0, 8'h00); step();
    for (int i = 1; i <= 3; i++) begin
      drive(1, 0, 1, 8'(i)); step();
    end
    chk("cod occ before", int'(occ_a[0]), 3);
    drive(0, 0, 1, 8'hEE); step();
    chk("cod occ", int'(occ_a[0]), 0);
    chk("cod q_vld", int'(qv_a[0]), 0);
    chk("hold-mode occ kept", int'(occ_a[1]), 3);
    drive(1, 1, 0, 8'h00); step();
    for (int i = 0; i < 4; i++) begin
      drive(1, 0, 1, 8'(8'h44 - 8'h11 * i)); step();
    end
    for (int i = 0; i < 5; i++) begin
      drive(0, 0, 1'($urandom), 8'($urandom)); step();
      chk("hold q", int'(q_a[1]), 8'h44);
      chk("hold occ", int'(occ_a[1]), 4);
    end
    drive(1, 0, 0, 8'h00); step();
    chk("resume q", int'(q_a[1]), 8'h33);
    chk("d5 occ", int'(occ_a[2]), 4);
    drive(1, 1, 1, 8'h77); step();
    chk("d5 flush occ", int'(occ_a[2]), 0);
    chk("d5 flush s0", int'(tap_a[2]), 0);
    drive(1, 0, 1, 8'hA1); step();
    drive(1, 0, 1, 8'hA2); step();
    drive(0, 0, 0, 8'h00);
    tsv[2] = 1;
    #1 chk("tap sel1", int'(tap_a[2]), 8'hA1);
    tsv[2] = 7;
    #1 chk("tap sel7", int'(tap_a[2]), 0);
    tsv[2] = 0;
    for (int i = 0; i < 4; i++) begin
      drive(1, 0, 1, 8'(8'hA1 + i)); step();
    end
    chk("pre-reset q", int'(q_a[0]), 8'hA1);
    rst_n = 0;
    model_clear();
    #1;
    chk("async reset q", int'(q_a[0]), 0);
    chk("async reset vld", int'(qv_a[0]), 0);
    chk("async reset occ", int'(occ_a[0]), 0);
    compare_all();
    step();
    rst_n = 1;
    lat = 0;
    for (int i = 1; i <= 8 && lat == 0; i++) begin
      drive(1, 0, 1, 8'hB0 + 8'(i)); step();
      if (qv_a[0]) lat = i;
    end
    chk("post-reset latency", lat, 4);
    chk("post-reset q", int'(q_a[0]), 8'hB1);
    for (int c = 0; c < 3000; c++) begin
      drive(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 31) == 0), 1'($urandom), 8'($urandom));
      for (int k = 0; k < 4; k++) tsv[k] = $urandom_range(0, (1 << tw[k]) - 1);
      if ($urandom_range(0, 199) == 0) begin
        rst_n = 0;
        model_clear();
        #1 compare_all();
        step();
        rst_n = 1;
      end else step();
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
